// File: rtl/lcd_fmt_pkg.sv
// Shared constants for the LCD value formatter: ASCII codes, FSM states and
// character positions within the 16-character display line.
package lcd_fmt_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FORMAT,
        ST_ISSUE
    } fmt_state_e;

    localparam int LINE_CHARS  = 16;
    localparam int LABEL_FIRST = 1;
    localparam int LABEL_LAST  = 8;
    localparam int COLON_POS   = 9;
    localparam int SIGN_POS    = 10;
    localparam int DIGIT_FIRST = 11;
    localparam int DIGIT_LAST  = 15;
    localparam int TRAIL_POS   = 16;

    // Char 1 is the leftmost, stored in the top byte of the [8*16:1] line.
    function automatic int char_lsb(input int pos);
        return 8 * (LINE_CHARS - pos) + 1;
    endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One shift-and-add-3 step of a 16-bit binary to 5-digit BCD conversion.
module bcd_shift_step (
    input  logic [19:0] bcd_in,
    input  logic [15:0] bin_in,
    output logic [19:0] bcd_out,
    output logic [15:0] bin_out
);

    logic [19:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < 5; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {bcd_out, bin_out} = {adj, bin_in} << 1;

endmodule

// File: rtl/lcd_value_formatter.sv
// Formats a signed 16-bit value plus an 8-char label into a 16-char LCD line
// and issues a rate-limited Go pulse to the LCD controller.
//
// state     | meaning
// ST_IDLE   | waiting for Start; captures label, sign and magnitude
// ST_SHIFT  | 16 cycles of serial binary-to-BCD conversion
// ST_FORMAT | writes the whole Display line in one edge
// ST_ISSUE  | waits for the refresh gap to expire, then pulses Go
module lcd_value_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 4096
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Start,
    input  logic [15:0]    Value,
    input  logic [8*8:1]   Label,
    output logic [8*16:1]  Display,
    output logic           Go,
    output logic           Busy
);

    localparam logic [15:0] GAP_RELOAD = 16'(REFRESH_CYCLES - 1);

    fmt_state_e    state_q, state_d;
    logic          go_d, go_q;
    logic [3:0]    bit_cnt_q;
    logic [19:0]   bcd_q, bcd_step;
    logic [15:0]   bin_q, bin_step;
    logic          sign_q;
    logic [8*8:1]  label_q;
    logic [15:0]   gap_q;
    logic [8*16:1] display_d;
    logic          leading;
    logic [3:0]    nib;

    bcd_shift_step u_step (
        .bcd_in  (bcd_q),
        .bin_in  (bin_q),
        .bcd_out (bcd_step),
        .bin_out (bin_step)
    );

    always_comb begin
        state_d = state_q;
        go_d    = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (Start) state_d = ST_SHIFT;
            ST_SHIFT:  if (bit_cnt_q == 4'd15) state_d = ST_FORMAT;
            ST_FORMAT: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (gap_q == 16'd0) begin
                    go_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Leading zeros in the first four digits are blanked; the units digit always shows.
    always_comb begin
        display_d = {LINE_CHARS{ASCII_SPACE}};
        leading   = 1'b1;
        nib       = 4'd0;
        for (int p = LABEL_FIRST; p <= LABEL_LAST; p++) begin
            display_d[char_lsb(p) +: 8] = label_q[8*(LABEL_LAST-p)+1 +: 8];
        end
        display_d[char_lsb(COLON_POS) +: 8] = ASCII_COLON;
        display_d[char_lsb(SIGN_POS) +: 8]  = sign_q ? ASCII_MINUS : ASCII_SPACE;
        for (int p = DIGIT_FIRST; p <= DIGIT_LAST; p++) begin
            nib = bcd_q[4*(DIGIT_LAST-p) +: 4];
            if (leading && nib == 4'd0 && p != DIGIT_LAST) begin
                display_d[char_lsb(p) +: 8] = ASCII_SPACE;
            end else begin
                leading = 1'b0;
                display_d[char_lsb(p) +: 8] = ASCII_ZERO + {4'd0, nib};
            end
        end
        display_d[char_lsb(TRAIL_POS) +: 8] = ASCII_SPACE;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            go_q      <= 1'b0;
            bit_cnt_q <= 4'd0;
            bcd_q     <= 20'd0;
            bin_q     <= 16'd0;
            sign_q    <= 1'b0;
            label_q   <= '0;
            gap_q     <= 16'd0;
            Display   <= {LINE_CHARS{ASCII_SPACE}};
        end else begin
            state_q <= state_d;
            go_q    <= go_d;

            if (go_d) begin
                gap_q <= GAP_RELOAD;
            end else if (gap_q != 16'd0) begin
                gap_q <= gap_q - 16'd1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        label_q   <= Label;
                        sign_q    <= Value[15];
                        bin_q     <= Value[15] ? (~Value + 16'd1) : Value;
                        bcd_q     <= 20'd0;
                        bit_cnt_q <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    bcd_q     <= bcd_step;
                    bin_q     <= bin_step;
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                ST_FORMAT: Display <= display_d;
                default: ;
            endcase
        end
    end

    assign Go   = go_q;
    assign Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Scoreboard bench for lcd_value_formatter: stimulus pushes expected lines,
// a negedge monitor checks each Go pulse against them.
module tb_lcd_value_formatter;

    localparam int REFRESH = 100;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic           Start = 1'b0;
    logic [15:0]    Value = '0;
    logic [8*8:1]   Label = '0;
    logic [8*16:1]  Display;
    logic           Go;
    logic           Busy;

    localparam logic [8*16:1] ALL_SPACES = "                ";

    lcd_value_formatter #(.REFRESH_CYCLES(REFRESH)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .Value   (Value),
        .Label   (Label),
        .Display (Display),
        .Go      (Go),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [8*16:1] disp;
        int            go_at;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            ncnt  = 0;
    logic          go_prev = 1'b0;
    logic [8*16:1] disp_prev = '0;

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_disp(input string nm, input logic [8*16:1] act, input logic [8*16:1] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        ncnt++;
        if (Rst && Go) begin
            if (go_prev) begin
                n_cmp++;
                n_err++;
                $display("FAIL go_width: Go high in consecutive cycles at cycle %0d", ncnt);
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_go: got Go at cycle %0d, expected none", ncnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_disp("go_display", Display, e.disp);
                check_int("go_cycle", ncnt, e.go_at);
                check_int("busy_at_go", int'(Busy), 0);
                check_disp("display_stable_before_go", disp_prev, Display);
            end
        end
        go_prev   = Go;
        disp_prev = Display;
    end

    task automatic sync();
        @(negedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    // Caller is synced; go_at < 0 means no Go is expected for this request.
    task automatic issue(input logic [15:0] v, input logic [8*8:1] l,
                         input logic [8*16:1] d, input int go_at);
        exp_t e;
        Value = v;
        Label = l;
        Start = 1'b1;
        if (go_at >= 0) begin
            e.disp  = d;
            e.go_at = go_at;
            sb.push_back(e);
        end
        sync();
        Start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            sync();
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d responses pending after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        int g;
        bit seen;

        idle(3);
        check_disp("reset_display", Display, ALL_SPACES);
        check_int("reset_go", int'(Go), 0);
        check_int("reset_busy", int'(Busy), 0);
        Rst = 1'b1;
        idle(2);

        // -1234 with an expired gap
        issue(16'hFB2E, "TEMP    ", "TEMP    :- 1234 ", ncnt + 19);
        check_int("busy_after_start", int'(Busy), 1);
        drain(40);
        check_int("busy_after_go", int'(Busy), 0);
        idle(REFRESH + 10);

        issue(16'h0000, "ZERO    ", "ZERO    :     0 ", ncnt + 19);
        drain(40);
        idle(REFRESH + 10);

        issue(16'h8000, "MIN     ", "MIN     :-32768 ", ncnt + 19);
        drain(40);
        idle(REFRESH + 10);

        issue(16'h7FFF, "MAX     ", "MAX     : 32767 ", ncnt + 19);
        drain(40);
        idle(REFRESH + 10);

        // Back-to-back: second Start lands in the Go cycle of the first
        issue(16'd5, "A       ", "A       :     5 ", ncnt + 19);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sync();
            if (Go) begin
                seen = 1'b1;
                break;
            end
        end
        check_int("first_go_seen", int'(seen), 1);
        g = ncnt;
        issue(16'hFFF9, "B       ", "B       :-    7 ", g + REFRESH);
        idle(16);
        check_disp("display_before_second_format", Display, "A       :     5 ");
        sync();
        check_disp("display_after_second_format", Display, "B       :-    7 ");
        drain(REFRESH + 20);
        idle(REFRESH + 10);

        // Start during SHIFT is dropped
        issue(16'd321, "X       ", "X       :   321 ", ncnt + 19);
        idle(4);
        Value = 16'd999;
        Start = 1'b1;
        sync();
        Start = 1'b0;
        drain(40);
        idle(REFRESH + 20);
        check_disp("display_after_ignored_start", Display, "X       :   321 ");

        // Reset in the middle of SHIFT
        issue(16'd1000, "R       ", ALL_SPACES, -1);
        idle(7);
        Rst = 1'b0;
        #1;
        check_disp("midreset_display", Display, ALL_SPACES);
        check_int("midreset_go", int'(Go), 0);
        check_int("midreset_busy", int'(Busy), 0);
        idle(3);
        Rst = 1'b1;
        idle(30);
        check_disp("post_reset_display", Display, ALL_SPACES);
        issue(16'd42, "AFTER   ", "AFTER   :    42 ", ncnt + 19);
        drain(40);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
